// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : Register-mapped SPI slave. Supports modes 0-3, 8-bit frames, MSB
//            first. All pin activity is synchronized into clk. The optional
//            4-entry RX FIFO is built when SPI_SLAVE_RX_FIFO_EN is defined;
//            otherwise a single RXDATA register is used.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq_spi_rx
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] OFS_CTRL = 4'h0;
    localparam logic [3:0] OFS_DATA = 4'h4;
    localparam logic [3:0] OFS_STAT = 4'h8;

    state_t      state_q, state_d;
    // Index 0/1 form the synchronizer; index 2 is the previous clean sample.
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  cs_sync_q, cs_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    // prime marks when the synchronizer holds real pin data after reset;
    // armed requires CS to be seen high before a falling edge may start a frame.
    logic [1:0]  prime_q, prime_d;
    logic        armed_q, armed_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        tx_pending_q, tx_pending_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        miso_q, miso_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;
    logic [31:0] data_o_q, data_o_d;

    logic        sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic        sample_edge, shift_edge, cs_fall, busy;
    logic        load, done_wr, rd_pop, overrun_set;
    logic [7:0]  load_val, rx_head;
    logic        rx_valid;
    logic [2:0]  occupancy;
    logic        unused_bits;

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        push, pop;
    assign rx_valid  = (count_q != 3'd0);
    assign rx_head   = fifo_q[rd_ptr_q];
    assign occupancy = count_q;
`else
    logic [7:0]  rxdata_q, rxdata_d;
    logic        rx_valid_q, rx_valid_d;
    assign rx_valid  = rx_valid_q;
    assign rx_head   = rxdata_q;
    assign occupancy = 3'd0;
`endif

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign lead_edge   = ctrl_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = ctrl_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = ctrl_q[2] ? trail_edge : lead_edge;
    // In mode CPHA=0 the trailing edge that closes the previous byte must not
    // disturb the freshly loaded bit7, so only shift after a sample this byte.
    assign shift_edge  = ctrl_q[2] ? lead_edge : (trail_edge && bit_cnt_q != 4'd0);
    assign cs_fall     = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
    assign busy        = (state_q != IDLE);
    assign done_wr     = (state_q == DONE);
    assign rd_pop      = rd_i && (raddr_i[3:0] == OFS_DATA);
    assign load_val    = tx_pending_q ? txdata_q : 8'hFF;
    assign unused_bits = ^{waddr_i[7:4], raddr_i[7:4], data_i[31:8], sel_i[3:1]};

    assign data_o      = data_o_q;
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & miso_q;
    assign irq_spi_rx  = irq_q;

    // Frame state machine: next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (bit_cnt_q == 4'd8) state_d = DONE;
            DONE:    state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
        if (!ctrl_q[0] || cs_sync_q[1]) state_d = IDLE;
    end

    // Datapath, register file and RX storage next values
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], spi_sclk};
        cs_sync_d    = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d  = {mosi_sync_q[0], spi_mosi};
        prime_d      = {prime_q[0], 1'b1};
        armed_d      = armed_q | (prime_q[1] & cs_sync_q[1]);
        ctrl_d       = ctrl_q;
        txdata_d     = txdata_q;
        tx_pending_d = tx_pending_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        overrun_d    = overrun_q;
        overrun_set  = 1'b0;
        data_o_d     = data_o_q;
        load         = (state_d == ACTIVE) && (state_q != ACTIVE);
        irq_d        = done_wr & ctrl_q[3];

        if (state_q == ACTIVE && bit_cnt_q != 4'd8) begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_sync_q[1]};
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end
            if (shift_edge) begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end
        if (load) begin
            tx_shift_d   = ctrl_q[2] ? load_val : {load_val[6:0], 1'b0};
            miso_d       = ctrl_q[2] ? 1'b0 : load_val[7];
            rx_shift_d   = 8'h00;
            bit_cnt_d    = 4'd0;
            tx_pending_d = 1'b0;
        end
        if (state_d == IDLE) begin
            bit_cnt_d = 4'd0;
            miso_d    = 1'b0;
        end

        // Bus writes come after the load so a same-cycle TXDATA write stays pending.
        if (we_i) begin
            case (waddr_i[3:0])
                OFS_CTRL: if (sel_i[0]) ctrl_d = data_i[3:0];
                OFS_DATA: begin
                    txdata_d     = data_i[7:0];
                    tx_pending_d = 1'b1;
                end
                OFS_STAT: if (data_i[2]) overrun_d = 1'b0;
                default:  ;
            endcase
        end

`ifdef SPI_SLAVE_RX_FIFO_EN
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = rd_pop && (count_q != 3'd0);
        push     = done_wr && (count_q != 3'd4 || pop);
        if (done_wr && !push) overrun_set = 1'b1;
        if (push) begin
            fifo_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        count_d = count_q + {2'b00, push} - {2'b00, pop};
`else
        rxdata_d   = rxdata_q;
        rx_valid_d = rx_valid_q;
        // A same-cycle pop frees the register, so the new byte is kept.
        if (done_wr) begin
            if (rx_valid_q && !rd_pop) begin
                overrun_set = 1'b1;
            end else begin
                rxdata_d   = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end else if (rd_pop) begin
            rx_valid_d = 1'b0;
        end
`endif
        if (overrun_set) overrun_d = 1'b1;

        if (rd_i) begin
            case (raddr_i[3:0])
                OFS_CTRL: data_o_d = {28'd0, ctrl_q};
                OFS_DATA: data_o_d = {24'd0, rx_head};
                OFS_STAT: data_o_d = {25'd0, occupancy, tx_pending_q, overrun_q, rx_valid, busy};
                default:  data_o_d = 32'd0;
            endcase
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // All other state: synchronizers, registers, shifters, RX storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            prime_q      <= 2'b00;
            armed_q      <= 1'b0;
            ctrl_q       <= 4'h0;
            txdata_q     <= 8'h00;
            tx_pending_q <= 1'b0;
            tx_shift_q   <= 8'h00;
            miso_q       <= 1'b0;
            rx_shift_q   <= 8'h00;
            bit_cnt_q    <= 4'd0;
            overrun_q    <= 1'b0;
            irq_q        <= 1'b0;
            data_o_q     <= 32'd0;
`ifdef SPI_SLAVE_RX_FIFO_EN
            fifo_q       <= '{default: 8'h00};
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
`else
            rxdata_q     <= 8'h00;
            rx_valid_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            prime_q      <= prime_d;
            armed_q      <= armed_d;
            ctrl_q       <= ctrl_d;
            txdata_q     <= txdata_d;
            tx_pending_q <= tx_pending_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            overrun_q    <= overrun_d;
            irq_q        <= irq_d;
            data_o_q     <= data_o_d;
`ifdef SPI_SLAVE_RX_FIFO_EN
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`else
            rxdata_q     <= rxdata_d;
            rx_valid_q   <= rx_valid_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have the following ports, in the order listed:
  clk  input  1  system clock; all logic is clocked on the rising edge.
  rst_n  input  1  reset, asynchronous, active-low.
  waddr_i  input  8  write address; only [3:0] is decoded.
  data_i  input  32  write data.
  sel_i  input  4  byte lane enables; honoured for the CTRL register only.
  we_i  input  1  write strobe.
  raddr_i  input  8  read address; only [3:0] is decoded.
  rd_i  input  1  read strobe.
  data_o  output  32  registered read data.
  spi_sclk  input  1  serial clock from the external master.
  spi_cs_n  input  1  chip select from the external master, active-low.
  spi_mosi  input  1  data from the master.
  spi_miso  output  1  data to the master.
  spi_miso_oe  output  1  MISO output enable; 1 = drive.
  irq_spi_rx  output  1  one-cycle pulse when a received byte completes.
REQ-002 SHALL implement the following registers:
  CTRL at offset 0x0: [0] enable, [1] CPOL, [2] CPHA, [3] irq_en.
  TXDATA/RXDATA at offset 0x4: a write loads TXDATA[7:0]; a read pops RXDATA.
  STATUS at offset 0x8: [0] busy, [1] rx_valid, [2] overrun (write 1 to clear), [3] tx_pending.

Function
REQ-003 SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-FF synchronizers, then detect edges on the synchronized values.
REQ-004 SHALL act on a pin edge exactly 3 clk after the edge; the master's SCLK high and low phases SHALL each be at least 4 clk.
REQ-005 SHALL, on a read, update data_o on the next clk edge; data_o SHALL hold its value when rd_i=0; unmapped offsets SHALL read as 0.
REQ-006 SHALL define the leading SCLK edge as the transition away from CPOL.
  CPHA=0: sample MOSI on the leading edge; shift MISO on the trailing edge.
  CPHA=1: shift MISO on the leading edge; sample MOSI on the trailing edge.
REQ-007 SHALL use a state machine with states IDLE, ACTIVE and DONE:
  IDLE->ACTIVE on synchronized CS falling, only when enable=1.
  ACTIVE->DONE in the cycle after the 8th sample edge.
  DONE->ACTIVE after 1 clk while CS remains low.
  any state->IDLE on CS high.
REQ-008 SHALL, on entry to ACTIVE, transfer TXDATA to the TX shifter and clear tx_pending; if tx_pending=0, the shifter SHALL be loaded with 0xFF.
REQ-009 SHALL transmit and receive MSB first.
  CPHA=0: MISO = bit7 immediately on the ACTIVE load.
  CPHA=1: MISO = bit7 on the first leading edge.
REQ-010 SHALL, in DONE, write the RX shifter to RXDATA, set rx_valid, and pulse irq_spi_rx for 1 clk if irq_en=1.
REQ-011 SHALL, when rx_valid=1 at the DONE write, discard the new byte and set overrun.
REQ-012 SHALL clear rx_valid on a read of offset 0x4.
  A read in the same cycle as the DONE write returns the old byte, stores the new byte, and does not set overrun.
REQ-013 SHALL, on CS deassertion before the 8th sample edge:
  discard the partial byte;
  raise no irq;
  leave rx_valid unchanged;
  reset the bit counter to 0.
REQ-014 SHALL, on a TXDATA write in the same cycle as a shifter load, load the old value into the shifter, store the new value in TXDATA, and leave tx_pending=1.
REQ-015 SHALL drive spi_miso_oe=1 only in ACTIVE/DONE; otherwise spi_miso_oe=0 and spi_miso=0.
REQ-016 SHALL, when enable=0, ignore all pins, stay in IDLE, and allow registers to remain accessible.
REQ-017 SHALL, when enable is cleared mid-frame, return to IDLE on the next clk and discard the partial byte.
REQ-018 SHALL report busy=1 exactly while the state machine is not in IDLE.

Reset
REQ-019 SHALL, while rst_n=0, clear all registers and shifters, set state=IDLE, and drive data_o=0, spi_miso=0, spi_miso_oe=0, irq_spi_rx=0.
REQ-020 SHALL load both synchronizer chains for spi_cs_n to 1 and both chains for spi_sclk to 0 during reset.
REQ-021 SHALL not begin a frame while CS is held low through the deassertion of reset; a fresh CS falling edge is required.

Configuration
REQ-022 SHALL, with SPI_SLAVE_RX_FIFO_EN defined, buffer received bytes in a 4-entry RX FIFO:
  rx_valid = FIFO not empty;
  overrun sets only when a byte completes with the FIFO full, and that byte is dropped;
  STATUS[6:4] = occupancy (0-4).
REQ-023 SHALL, without SPI_SLAVE_RX_FIFO_EN, use a single RXDATA register with the REQ-011 semantics; STATUS[6:4] reads 0.

Verification
REQ-024 Mode 0, TXDATA=0xA5, master sends 0x3C: master receives 0xA5; RXDATA=0x3C; rx_valid=1; one irq pulse.
REQ-025 Mode 3, no TXDATA write, master sends 0x81: master receives 0xFF; RXDATA=0x81.
REQ-026 Two bytes 0x11, 0x22 in one CS assertion, no RX read in between: RXDATA=0x11; overrun=1. With the FIFO enabled: occupancy=2, reads return 0x11 then 0x22.
REQ-027 CS raised after 5 bits: no irq; rx_valid=0; next full frame 0x5A is received correctly.
REQ-028 rst_n asserted mid-frame: all outputs are 0 within the reset; after release with CS low, no activity until a new CS fall.
REQ-029 Write 1 to STATUS[2] after an overrun: overrun=0; rx_valid is unchanged.
